// File: rtl/register_read_stage_if.sv
// register_read_stage_if
//   Bundles the issue, regfile-read, bypass, branch-update and execute-request
//   signals of the integer register-read stage.
//   modport master : the surrounding pipeline (drives issue/rf data/bypass/brupdate/kill)
//   modport slave  : the register-read stage itself
//   Signals:
//     io_iss_*        issued uop and its decoded fields
//     io_rf_raddr*    regfile read addresses (stage -> regfile)
//     io_rf_rdata*    regfile read data, one cycle after the address
//     io_byp_*        writeback bypass ports, port i at slice i
//     io_brupdate_*   branch resolve / mispredict masks for this cycle
//     io_kill         pipeline flush
//     io_exe_*        execute request
interface register_read_stage_if #(
  parameter int XLEN   = 64,
  parameter int PREG_W = 7,
  parameter int MAXBR  = 12,
  parameter int NBYP   = 2
);
  logic                     io_iss_valid;
  logic [MAXBR-1:0]         io_iss_uop_br_mask;
  logic [PREG_W-1:0]        io_iss_uop_prs1;
  logic [PREG_W-1:0]        io_iss_uop_prs2;
  logic [PREG_W-1:0]        io_iss_uop_pdst;
  logic [16:0]              io_iss_uop_ctrl;
  logic [19:0]              io_iss_uop_imm_packed;
  logic [PREG_W-1:0]        io_rf_raddr1;
  logic [PREG_W-1:0]        io_rf_raddr2;
  logic [XLEN-1:0]          io_rf_rdata1;
  logic [XLEN-1:0]          io_rf_rdata2;
  logic [NBYP-1:0]          io_byp_valid;
  logic [NBYP*PREG_W-1:0]   io_byp_pdst;
  logic [NBYP*XLEN-1:0]     io_byp_data;
  logic [MAXBR-1:0]         io_brupdate_resolve_mask;
  logic [MAXBR-1:0]         io_brupdate_mispredict_mask;
  logic                     io_kill;
  logic                     io_exe_valid;
  logic [MAXBR-1:0]         io_exe_uop_br_mask;
  logic [PREG_W-1:0]        io_exe_uop_pdst;
  logic [16:0]              io_exe_uop_ctrl;
  logic [19:0]              io_exe_uop_imm_packed;
  logic [XLEN-1:0]          io_exe_rs1_data;
  logic [XLEN-1:0]          io_exe_rs2_data;

  modport master (
    output io_iss_valid, io_iss_uop_br_mask, io_iss_uop_prs1, io_iss_uop_prs2,
           io_iss_uop_pdst, io_iss_uop_ctrl, io_iss_uop_imm_packed,
           io_rf_rdata1, io_rf_rdata2, io_byp_valid, io_byp_pdst, io_byp_data,
           io_brupdate_resolve_mask, io_brupdate_mispredict_mask, io_kill,
    input  io_rf_raddr1, io_rf_raddr2, io_exe_valid, io_exe_uop_br_mask,
           io_exe_uop_pdst, io_exe_uop_ctrl, io_exe_uop_imm_packed,
           io_exe_rs1_data, io_exe_rs2_data
  );

  modport slave (
    input  io_iss_valid, io_iss_uop_br_mask, io_iss_uop_prs1, io_iss_uop_prs2,
           io_iss_uop_pdst, io_iss_uop_ctrl, io_iss_uop_imm_packed,
           io_rf_rdata1, io_rf_rdata2, io_byp_valid, io_byp_pdst, io_byp_data,
           io_brupdate_resolve_mask, io_brupdate_mispredict_mask, io_kill,
    output io_rf_raddr1, io_rf_raddr2, io_exe_valid, io_exe_uop_br_mask,
           io_exe_uop_pdst, io_exe_uop_ctrl, io_exe_uop_imm_packed,
           io_exe_rs1_data, io_exe_rs2_data
  );
endinterface

// File: rtl/register_read_stage.sv
// register_read_stage
//   Two-stage integer register-read pipeline. Issue drives the regfile read
//   addresses combinationally; S1 holds the uop while the read is in flight and
//   selects each operand (x0 / bypass / regfile); S2 is the execute-request
//   register. Fixed 2-cycle latency, no backpressure.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-low; clears only the stage valids
//     rr     register_read_stage_if.slave bundle (issue, rf, bypass, brupdate, kill, exe)
module register_read_stage #(
  parameter int XLEN   = 64,
  parameter int PREG_W = 7,
  parameter int MAXBR  = 12,
  parameter int NBYP   = 2
) (
  input logic                  clock,
  input logic                  reset,
  register_read_stage_if.slave rr
);

  localparam int CTRL_W = 17;
  localparam int IMM_W  = 20;

  logic                s1_valid;
  logic [MAXBR-1:0]    s1_br_mask;
  logic [PREG_W-1:0]   s1_prs1;
  logic [PREG_W-1:0]   s1_prs2;
  logic [PREG_W-1:0]   s1_pdst;
  logic [CTRL_W-1:0]   s1_ctrl;
  logic [IMM_W-1:0]    s1_imm;

  logic                s2_valid;
  logic [MAXBR-1:0]    s2_br_mask;
  logic [PREG_W-1:0]   s2_pdst;
  logic [CTRL_W-1:0]   s2_ctrl;
  logic [IMM_W-1:0]    s2_imm;
  logic [XLEN-1:0]     s2_rs1;
  logic [XLEN-1:0]     s2_rs2;

  logic                iss_survives;
  logic                s1_survives;
  logic [XLEN-1:0]     s1_rs1;
  logic [XLEN-1:0]     s1_rs2;

  // x0 reads as zero; otherwise the lowest-index matching bypass port wins
  // over the regfile data.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [PREG_W-1:0]      prs,
    input logic [XLEN-1:0]        rdata,
    input logic [NBYP-1:0]        byp_valid,
    input logic [NBYP*PREG_W-1:0] byp_pdst,
    input logic [NBYP*XLEN-1:0]   byp_data
  );
    logic [XLEN-1:0] res;
    logic            hit;
    res = rdata;
    hit = 1'b0;
    for (int i = 0; i < NBYP; i++) begin
      if (!hit && byp_valid[i] && (byp_pdst[i*PREG_W +: PREG_W] == prs)) begin
        res = byp_data[i*XLEN +: XLEN];
        hit = 1'b1;
      end
    end
    if (prs == '0) begin
      res = '0;
    end
    return res;
  endfunction

  assign rr.io_rf_raddr1 = rr.io_iss_uop_prs1;
  assign rr.io_rf_raddr2 = rr.io_iss_uop_prs2;

  assign iss_survives = rr.io_iss_valid && !rr.io_kill &&
                        ((rr.io_iss_uop_br_mask & rr.io_brupdate_mispredict_mask) == '0);
  assign s1_survives  = s1_valid && !rr.io_kill &&
                        ((s1_br_mask & rr.io_brupdate_mispredict_mask) == '0);

  assign s1_rs1 = sel_operand(s1_prs1, rr.io_rf_rdata1, rr.io_byp_valid,
                              rr.io_byp_pdst, rr.io_byp_data);
  assign s1_rs2 = sel_operand(s1_prs2, rr.io_rf_rdata2, rr.io_byp_valid,
                              rr.io_byp_pdst, rr.io_byp_data);

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= iss_survives;
      s2_valid <= s1_survives;
    end
  end

  // Payload registers carry no reset; the valids qualify them.
  always_ff @(posedge clock) begin
    s1_br_mask <= rr.io_iss_uop_br_mask & ~rr.io_brupdate_resolve_mask;
    s1_prs1    <= rr.io_iss_uop_prs1;
    s1_prs2    <= rr.io_iss_uop_prs2;
    s1_pdst    <= rr.io_iss_uop_pdst;
    s1_ctrl    <= rr.io_iss_uop_ctrl;
    s1_imm     <= rr.io_iss_uop_imm_packed;

    s2_br_mask <= s1_br_mask & ~rr.io_brupdate_resolve_mask;
    s2_pdst    <= s1_pdst;
    s2_ctrl    <= s1_ctrl;
    s2_imm     <= s1_imm;
    s2_rs1     <= s1_rs1;
    s2_rs2     <= s1_rs2;
  end

  // Execute side sees this cycle's resolves immediately; kills here take
  // effect next cycle, so exe_valid is not gated combinationally.
  assign rr.io_exe_valid          = s2_valid;
  assign rr.io_exe_uop_br_mask    = s2_br_mask & ~rr.io_brupdate_resolve_mask;
  assign rr.io_exe_uop_pdst       = s2_pdst;
  assign rr.io_exe_uop_ctrl       = s2_ctrl;
  assign rr.io_exe_uop_imm_packed = s2_imm;
  assign rr.io_exe_rs1_data       = s2_rs1;
  assign rr.io_exe_rs2_data       = s2_rs2;

endmodule

// File: tb/tb_register_read_stage.sv
// tb_register_read_stage
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based model of in-flight uops (age 1 = read in flight, age 2 = at exe).
module tb_register_read_stage;
  localparam int XLEN   = 64;
  localparam int PREG_W = 7;
  localparam int MAXBR  = 12;
  localparam int NBYP   = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  register_read_stage_if #(.XLEN(XLEN), .PREG_W(PREG_W), .MAXBR(MAXBR), .NBYP(NBYP)) rr_if ();

  register_read_stage #(.XLEN(XLEN), .PREG_W(PREG_W), .MAXBR(MAXBR), .NBYP(NBYP)) dut (
    .clock (clock),
    .reset (reset),
    .rr    (rr_if)
  );

  typedef struct {
    int          age;
    logic [11:0] br;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [6:0]  pdst;
    logic [16:0] ctrl;
    logic [19:0] imm;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } model_uop_t;

  model_uop_t mq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_operand(input logic [6:0] prs, input logic [63:0] rdata);
    if (prs == 7'd0) return 64'd0;
    for (int i = 0; i < NBYP; i++)
      if (rr_if.io_byp_valid[i] && rr_if.io_byp_pdst[i*PREG_W +: PREG_W] == prs)
        return rr_if.io_byp_data[i*XLEN +: XLEN];
    return rdata;
  endfunction

  task automatic idle_inputs();
    rr_if.io_iss_valid                = 1'b0;
    rr_if.io_iss_uop_br_mask          = 12'($urandom);
    rr_if.io_iss_uop_prs1             = 7'($urandom);
    rr_if.io_iss_uop_prs2             = 7'($urandom);
    rr_if.io_iss_uop_pdst             = 7'($urandom);
    rr_if.io_iss_uop_ctrl             = 17'($urandom);
    rr_if.io_iss_uop_imm_packed       = 20'($urandom);
    rr_if.io_rf_rdata1                = {$urandom, $urandom};
    rr_if.io_rf_rdata2                = {$urandom, $urandom};
    rr_if.io_byp_valid                = '0;
    rr_if.io_byp_pdst                 = 14'($urandom);
    rr_if.io_byp_data                 = {$urandom, $urandom, $urandom, $urandom};
    rr_if.io_brupdate_resolve_mask    = '0;
    rr_if.io_brupdate_mispredict_mask = '0;
    rr_if.io_kill                     = 1'b0;
  endtask

  task automatic issue(input logic [6:0] prs1, input logic [6:0] prs2,
                       input logic [6:0] pdst, input logic [11:0] br);
    rr_if.io_iss_valid       = 1'b1;
    rr_if.io_iss_uop_prs1    = prs1;
    rr_if.io_iss_uop_prs2    = prs2;
    rr_if.io_iss_uop_pdst    = pdst;
    rr_if.io_iss_uop_br_mask = br;
  endtask

  task automatic random_inputs();
    idle_inputs();
    rr_if.io_iss_valid       = ($urandom_range(0, 9) < 7);
    rr_if.io_iss_uop_prs1    = 7'($urandom_range(0, 7));
    rr_if.io_iss_uop_prs2    = 7'($urandom_range(0, 7));
    rr_if.io_iss_uop_br_mask = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom);
    rr_if.io_byp_valid       = 2'($urandom);
    rr_if.io_byp_pdst        = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
    if ($urandom_range(0, 3) == 0)
      rr_if.io_brupdate_resolve_mask = 12'($urandom);
    if ($urandom_range(0, 5) == 0)
      rr_if.io_brupdate_mispredict_mask = 12'd1 << $urandom_range(0, 11);
    rr_if.io_kill = ($urandom_range(0, 29) == 0);
    reset         = ($urandom_range(0, 49) != 0);
  endtask

  // Compare DUT outputs against the model for the current cycle.
  task automatic check_outputs();
    int idx;
    idx = -1;
    #1;
    chk("rf_raddr1", 64'(rr_if.io_rf_raddr1), 64'(rr_if.io_iss_uop_prs1));
    chk("rf_raddr2", 64'(rr_if.io_rf_raddr2), 64'(rr_if.io_iss_uop_prs2));
    foreach (mq[i]) if (mq[i].age == 2) idx = i;
    chk("exe_valid", 64'(rr_if.io_exe_valid), (idx >= 0) ? 64'd1 : 64'd0);
    if (idx >= 0) begin
      chk("exe_pdst",    64'(rr_if.io_exe_uop_pdst),       64'(mq[idx].pdst));
      chk("exe_ctrl",    64'(rr_if.io_exe_uop_ctrl),       64'(mq[idx].ctrl));
      chk("exe_imm",     64'(rr_if.io_exe_uop_imm_packed), 64'(mq[idx].imm));
      chk("exe_rs1",     rr_if.io_exe_rs1_data,            mq[idx].rs1);
      chk("exe_rs2",     rr_if.io_exe_rs2_data,            mq[idx].rs2);
      chk("exe_br_mask", 64'(rr_if.io_exe_uop_br_mask),
          64'(mq[idx].br & ~rr_if.io_brupdate_resolve_mask));
    end
  endtask

  // Apply this cycle's events to the model, then move to the next cycle.
  task automatic advance();
    model_uop_t nq[$];
    model_uop_t e;
    logic [11:0] misp;
    logic [11:0] resv;
    misp = rr_if.io_brupdate_mispredict_mask;
    resv = rr_if.io_brupdate_resolve_mask;
    foreach (mq[i]) begin
      e = mq[i];
      if (e.age == 1 && reset && !rr_if.io_kill && ((e.br & misp) == 12'd0)) begin
        e.rs1 = ref_operand(e.prs1, rr_if.io_rf_rdata1);
        e.rs2 = ref_operand(e.prs2, rr_if.io_rf_rdata2);
        e.br  = e.br & ~resv;
        e.age = 2;
        nq.push_back(e);
      end
    end
    if (rr_if.io_iss_valid && reset && !rr_if.io_kill &&
        ((rr_if.io_iss_uop_br_mask & misp) == 12'd0)) begin
      e.age  = 1;
      e.br   = rr_if.io_iss_uop_br_mask & ~resv;
      e.prs1 = rr_if.io_iss_uop_prs1;
      e.prs2 = rr_if.io_iss_uop_prs2;
      e.pdst = rr_if.io_iss_uop_pdst;
      e.ctrl = rr_if.io_iss_uop_ctrl;
      e.imm  = rr_if.io_iss_uop_imm_packed;
      e.rs1  = '0;
      e.rs2  = '0;
      nq.push_back(e);
    end
    mq = nq;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_exe_valid", 64'(rr_if.io_exe_valid), 64'd0);
    reset = 1'b1;

    // Basic regfile operands.
    idle_inputs(); issue(7'd5, 7'd9, 7'h21, 12'h000); check_outputs(); advance();
    idle_inputs(); rr_if.io_rf_rdata1 = 64'h11; rr_if.io_rf_rdata2 = 64'h22;
    check_outputs(); advance();
    idle_inputs(); check_outputs();
    chk("basic_valid", 64'(rr_if.io_exe_valid), 64'd1);
    chk("basic_rs1", rr_if.io_exe_rs1_data, 64'h11);
    chk("basic_rs2", rr_if.io_exe_rs2_data, 64'h22);
    advance();

    // x0 and lowest-index bypass priority.
    idle_inputs(); issue(7'd5, 7'd0, 7'h22, 12'h000); check_outputs(); advance();
    idle_inputs();
    rr_if.io_rf_rdata1 = 64'hFFFF; rr_if.io_rf_rdata2 = 64'hFFFF;
    rr_if.io_byp_valid = 2'b11;
    rr_if.io_byp_pdst  = {7'd5, 7'd5};
    rr_if.io_byp_data  = {64'hB, 64'hA};
    check_outputs(); advance();
    idle_inputs(); check_outputs();
    chk("byp_rs1", rr_if.io_exe_rs1_data, 64'hA);
    chk("x0_rs2",  rr_if.io_exe_rs2_data, 64'h0);
    advance();

    // Mispredict kill in S1 while a concurrent independent uop survives.
    idle_inputs(); issue(7'd1, 7'd2, 7'h31, 12'h004); check_outputs(); advance();
    idle_inputs(); issue(7'd3, 7'd4, 7'h32, 12'h001);
    rr_if.io_brupdate_mispredict_mask = 12'h004;
    check_outputs(); advance();
    idle_inputs(); check_outputs();
    chk("misp_killed", 64'(rr_if.io_exe_valid), 64'd0);
    advance();
    idle_inputs(); check_outputs();
    chk("misp_survivor_valid", 64'(rr_if.io_exe_valid), 64'd1);
    chk("misp_survivor_pdst", 64'(rr_if.io_exe_uop_pdst), 64'h32);
    advance();

    // Resolve clears a mask bit on the way to exe.
    idle_inputs(); issue(7'd6, 7'd7, 7'h33, 12'h006); check_outputs(); advance();
    idle_inputs(); rr_if.io_brupdate_resolve_mask = 12'h002; check_outputs(); advance();
    idle_inputs(); check_outputs();
    chk("resolve_valid", 64'(rr_if.io_exe_valid), 64'd1);
    chk("resolve_br_mask", 64'(rr_if.io_exe_uop_br_mask), 64'h004);
    advance();

    // Back-to-back issue with a flush on the third.
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); issue(7'(k + 1), 7'(k + 2), 7'(8'h41 + k), 12'h000);
      if (k == 2) rr_if.io_kill = 1'b1;
      check_outputs();
      if (k == 2) begin
        chk("kill_first_valid", 64'(rr_if.io_exe_valid), 64'd1);
        chk("kill_first_pdst", 64'(rr_if.io_exe_uop_pdst), 64'h41);
      end
      if (k == 3) chk("kill_second_gone", 64'(rr_if.io_exe_valid), 64'd0);
      advance();
    end
    idle_inputs(); check_outputs();
    chk("kill_third_gone", 64'(rr_if.io_exe_valid), 64'd0);
    advance();
    idle_inputs(); check_outputs();
    chk("kill_fourth_valid", 64'(rr_if.io_exe_valid), 64'd1);
    chk("kill_fourth_pdst", 64'(rr_if.io_exe_uop_pdst), 64'h44);
    advance();

    // Reset pulse with both stages occupied.
    idle_inputs(); issue(7'd1, 7'd1, 7'h51, 12'h000); check_outputs(); advance();
    idle_inputs(); issue(7'd2, 7'd2, 7'h52, 12'h000); check_outputs(); advance();
    idle_inputs(); issue(7'd3, 7'd3, 7'h53, 12'h000); reset = 1'b0;
    check_outputs();
    chk("rstpulse_pre_valid", 64'(rr_if.io_exe_valid), 64'd1);
    advance();
    reset = 1'b1;
    idle_inputs(); check_outputs();
    chk("rstpulse_valid_1", 64'(rr_if.io_exe_valid), 64'd0);
    advance();
    idle_inputs(); check_outputs();
    chk("rstpulse_valid_2", 64'(rr_if.io_exe_valid), 64'd0);
    advance();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      check_outputs();
      advance();
    end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      idle_inputs();
      check_outputs();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
